// File: rtl/dvp_axis_packer_if.sv
// AXI-Stream word channel between the DVP packer and the downstream FIFO.
interface dvp_axis_packer_if #(
  parameter int DATA_WIDTH = 64
);
  logic                  tvalid;
  logic                  tready;
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tuser;
  logic                  tlast;

  modport master (output tvalid, tdata, tuser, tlast, input tready);
  modport slave  (input tvalid, tdata, tuser, tlast, output tready);
endinterface

// File: rtl/dvp_axis_packer.sv
// DVP capture front end: frame decimation, K-beat packing into AXI-Stream words, SOF/EOL markers.
// Optional crop window enabled by defining DVP_CROP_EN.
module dvp_axis_packer #(
  parameter int P_DVP_DATA_WIDTH  = 8,
  parameter int P_AXIS_DATA_WIDTH = 64,
  parameter int P_CNT_WIDTH       = 12
) (
  input  logic                        i_dvp_pclk,
  input  logic                        i_dvp_rst,
  input  logic                        i_dvp_vsync,
  input  logic                        i_dvp_href,
  input  logic [P_DVP_DATA_WIDTH-1:0] i_dvp_data,
  input  logic                        i_dvp_ena,
  input  logic [7:0]                  i_dvp_drop_vsync,
  input  logic                        i_axis_endian,
`ifdef DVP_CROP_EN
  input  logic [P_CNT_WIDTH-1:0]      i_crop_x0,
  input  logic [P_CNT_WIDTH-1:0]      i_crop_x1,
  input  logic [P_CNT_WIDTH-1:0]      i_crop_y0,
  input  logic [P_CNT_WIDTH-1:0]      i_crop_y1,
`endif
  dvp_axis_packer_if.master           m_axis,
  output logic [15:0]                 o_frame_cnt,
  output logic [15:0]                 o_ovf_cnt
);
  localparam int K  = P_AXIS_DATA_WIDTH / P_DVP_DATA_WIDTH;
  localparam int BW = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SYNC, S_ACTIVE, S_SKIP} state_t;
  state_t state;

  logic                         vsync_r, vsync_q, href_r, href_q, ena_r, endian_r;
  logic [P_DVP_DATA_WIDTH-1:0]  data_r, data_q;
  logic [7:0]                   drop_r, skip;
  logic [P_AXIS_DATA_WIDTH-1:0] pack_buf, merged, tdata_q;
  logic [BW-1:0]                pack_cnt, slot;
  logic                         tvalid_q, tuser_q, tlast_q, sof_pend;
  logic                         vs_rise, vs_fall, line_end, in_win, last_kept, beat, word_done;

  always_ff @(posedge i_dvp_pclk or posedge i_dvp_rst) begin
    if (i_dvp_rst) begin
      vsync_r  <= 1'b0;
      vsync_q  <= 1'b0;
      href_r   <= 1'b0;
      href_q   <= 1'b0;
      data_r   <= '0;
      data_q   <= '0;
      ena_r    <= 1'b0;
      endian_r <= 1'b0;
      drop_r   <= '0;
    end else begin
      vsync_r  <= i_dvp_vsync;
      vsync_q  <= vsync_r;
      href_r   <= i_dvp_href;
      href_q   <= href_r;
      data_r   <= i_dvp_data;
      data_q   <= data_r;
      ena_r    <= i_dvp_ena;
      endian_r <= i_axis_endian;
      drop_r   <= i_dvp_drop_vsync;
    end
  end

  // Beats are consumed from the second stage so the first stage acts as
  // one-beat lookahead: a beat is the last of its line when href_r is low.
  assign vs_rise  = vsync_r & ~vsync_q;
  assign vs_fall  = ~vsync_r & vsync_q;
  assign line_end = href_q & ~href_r;

`ifdef DVP_CROP_EN
  logic [P_CNT_WIDTH-1:0] x0_r, x1_r, y0_r, y1_r, col, line_idx;

  always_ff @(posedge i_dvp_pclk or posedge i_dvp_rst) begin
    if (i_dvp_rst) begin
      x0_r     <= '0;
      x1_r     <= '0;
      y0_r     <= '0;
      y1_r     <= '0;
      col      <= '0;
      line_idx <= '0;
    end else begin
      x0_r <= i_crop_x0;
      x1_r <= i_crop_x1;
      y0_r <= i_crop_y0;
      y1_r <= i_crop_y1;
      if (href_r && !href_q)
        col <= '0;
      else if (href_q && col != '1)
        col <= col + P_CNT_WIDTH'(1);
      if (vs_fall)
        line_idx <= '0;
      else if (line_end && line_idx != '1)
        line_idx <= line_idx + P_CNT_WIDTH'(1);
    end
  end

  assign in_win    = (col >= x0_r) && (col <= x1_r) && (line_idx >= y0_r) && (line_idx <= y1_r);
  assign last_kept = in_win && (line_end || col == x1_r);
`else
  assign in_win    = 1'b1;
  assign last_kept = line_end;
`endif

  assign beat      = href_q && (state == S_ACTIVE) && !vs_rise && in_win;
  assign slot      = endian_r ? (BW'(K - 1) - pack_cnt) : pack_cnt;
  assign word_done = beat && ((pack_cnt == BW'(K - 1)) || last_kept);

  always_comb begin
    merged = pack_buf;
    merged[int'(slot) * P_DVP_DATA_WIDTH +: P_DVP_DATA_WIDTH] = data_q;
  end

  always_ff @(posedge i_dvp_pclk or posedge i_dvp_rst) begin
    if (i_dvp_rst) begin
      state       <= S_IDLE;
      skip        <= '0;
      o_frame_cnt <= '0;
    end else if (vs_rise) begin
      if (state == S_ACTIVE)
        o_frame_cnt <= o_frame_cnt + 16'd1;
      if (!ena_r)
        state <= S_IDLE;
      else begin
        case (state)
          S_IDLE:   state <= S_SYNC;
          S_SYNC:   state <= S_SYNC;
          S_ACTIVE: state <= (skip != 8'd0) ? S_SKIP : S_SYNC;
          S_SKIP: begin
            skip <= skip - 8'd1;
            if (skip == 8'd1)
              state <= S_SYNC;
          end
          default:  state <= S_IDLE;
        endcase
      end
    end else if (vs_fall && state == S_SYNC) begin
      state <= S_ACTIVE;
      skip  <= drop_r;
    end
  end

  always_ff @(posedge i_dvp_pclk or posedge i_dvp_rst) begin
    if (i_dvp_rst) begin
      pack_buf  <= '0;
      pack_cnt  <= '0;
      tvalid_q  <= 1'b0;
      tdata_q   <= '0;
      tuser_q   <= 1'b0;
      tlast_q   <= 1'b0;
      sof_pend  <= 1'b0;
      o_ovf_cnt <= '0;
    end else begin
      if (vs_rise || state != S_ACTIVE || word_done) begin
        pack_buf <= '0;
        pack_cnt <= '0;
      end else if (beat) begin
        pack_buf <= merged;
        pack_cnt <= pack_cnt + BW'(1);
      end

      if (state == S_SYNC && vs_fall)
        sof_pend <= 1'b1;

      // A dropped word leaves sof_pend set so the frame marker rides on the next word.
      if (word_done && (!tvalid_q || m_axis.tready)) begin
        tvalid_q <= 1'b1;
        tdata_q  <= merged;
        tuser_q  <= sof_pend;
        tlast_q  <= last_kept;
        sof_pend <= 1'b0;
      end else if (word_done) begin
        if (o_ovf_cnt != '1)
          o_ovf_cnt <= o_ovf_cnt + 16'd1;
      end else if (tvalid_q && m_axis.tready) begin
        tvalid_q <= 1'b0;
        tuser_q  <= 1'b0;
      end
    end
  end

  assign m_axis.tvalid = tvalid_q;
  assign m_axis.tdata  = tdata_q;
  assign m_axis.tuser  = tuser_q;
  assign m_axis.tlast  = tlast_q;
endmodule

// File: tb/tb_dvp_axis_packer.sv
// Randomized self-checking bench for dvp_axis_packer against a line/frame-level reference model.
module tb_dvp_axis_packer;
  localparam int DW = 8;
  localparam int AW = 64;
  localparam int CW = 12;
  localparam int K  = AW / DW;

  logic          clk = 1'b0;
  logic          rst, vsync, href, ena, endian;
  logic [DW-1:0] data;
  logic [7:0]    drop;
  logic [15:0]   frame_cnt, ovf_cnt;
`ifdef DVP_CROP_EN
  logic [CW-1:0] x0, x1, y0, y1;
`endif

  dvp_axis_packer_if #(.DATA_WIDTH(AW)) axis ();

  typedef struct packed {
    logic [AW-1:0] d;
    logic          u;
    logic          l;
  } word_t;

  word_t got[$];
  word_t exp_q[$];
  int    tests = 0;
  int    fails = 0;
  bit    sof;

  always #5 clk = ~clk;

  dvp_axis_packer #(
    .P_DVP_DATA_WIDTH (DW),
    .P_AXIS_DATA_WIDTH(AW),
    .P_CNT_WIDTH      (CW)
  ) dut (
    .i_dvp_pclk      (clk),
    .i_dvp_rst       (rst),
    .i_dvp_vsync     (vsync),
    .i_dvp_href      (href),
    .i_dvp_data      (data),
    .i_dvp_ena       (ena),
    .i_dvp_drop_vsync(drop),
    .i_axis_endian   (endian),
`ifdef DVP_CROP_EN
    .i_crop_x0       (x0),
    .i_crop_x1       (x1),
    .i_crop_y0       (y0),
    .i_crop_y1       (y1),
`endif
    .m_axis          (axis),
    .o_frame_cnt     (frame_cnt),
    .o_ovf_cnt       (ovf_cnt)
  );

  // Words that will be accepted on the coming rising edge.
  always @(negedge clk) begin
    #1;
    if (!rst && axis.tvalid === 1'b1 && axis.tready === 1'b1)
      got.push_back({axis.tdata, axis.tuser, axis.tlast});
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, tests %0d", tests);
    $fatal(1);
  end

  task automatic do_reset();
    rst = 1'b1; vsync = 1'b0; href = 1'b0; data = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    got.delete(); exp_q.delete(); sof = 1'b0;
  endtask

  // Reference: split the line into K-beat chunks, place beat i by endianness, pad with zeros.
  task automatic model_line(input logic [DW-1:0] px[$]);
    for (int s = 0; s < px.size(); s += K) begin
      word_t w;
      w = '0;
      for (int i = 0; i < K; i++) begin
        if (s + i < px.size()) begin
          int pos = endian ? (K - 1 - i) : i;
          w.d[pos*DW +: DW] = px[s+i];
        end
      end
      w.l = (s + K >= px.size());
      w.u = sof;
      sof = 1'b0;
      exp_q.push_back(w);
    end
  endtask

  task automatic send_frame(input int nlines, input int nbeats, input bit cap, input bit ramp);
    logic [DW-1:0] px[$];
    vsync = 1'b1; repeat (4) @(negedge clk);
    vsync = 1'b0; repeat (3) @(negedge clk);
    if (cap) sof = 1'b1;
    for (int l = 0; l < nlines; l++) begin
      px.delete();
      for (int b = 0; b < nbeats; b++) begin
        href = 1'b1;
        data = ramp ? DW'(b) : DW'($urandom);
        px.push_back(data);
        @(negedge clk);
      end
      href = 1'b0; data = '0;
      repeat (4) @(negedge clk);
      if (cap) model_line(px);
    end
  endtask

  task automatic close_frame();
    vsync = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset();
    axis.tready = 1'b1; ena = 1'b1; endian = 1'b0; drop = '0;
    rst = 1'b1; vsync = 1'b1; href = 1'b1; data = DW'($urandom);
    repeat (2) @(negedge clk);
    tests++; if (axis.tvalid !== 1'b0) begin fails++; $display("FAIL reset_tvalid: got %b, expected 0", axis.tvalid); end
    tests++; if (axis.tuser !== 1'b0) begin fails++; $display("FAIL reset_tuser: got %b, expected 0", axis.tuser); end
    tests++; if (axis.tlast !== 1'b0) begin fails++; $display("FAIL reset_tlast: got %b, expected 0", axis.tlast); end
    tests++; if (axis.tdata !== '0) begin fails++; $display("FAIL reset_tdata: got %h, expected 0", axis.tdata); end
    tests++; if (frame_cnt !== 16'd0) begin fails++; $display("FAIL reset_frame_cnt: got %0d, expected 0", frame_cnt); end
    tests++; if (ovf_cnt !== 16'd0) begin fails++; $display("FAIL reset_ovf_cnt: got %0d, expected 0", ovf_cnt); end
  endtask

  task automatic test_pattern();
    logic [AW-1:0] lit;
    for (int e = 0; e < 2; e++) begin
      endian = e[0]; drop = '0; ena = 1'b1; axis.tready = 1'b1;
      do_reset();
      send_frame(2, 16, 1'b1, 1'b1);
      close_frame();
      lit = e ? 64'h0001020304050607 : 64'h0706050403020100;
      tests++; if (got.size() == 0 || got[0].d !== lit) begin fails++; $display("FAIL pattern_first_word e%0d: got %h, expected %h", e, (got.size() > 0) ? got[0].d : '0, lit); end
      tests++; if (got.size() != exp_q.size()) begin fails++; $display("FAIL pattern_count e%0d: got %0d words, expected %0d", e, got.size(), exp_q.size()); end
      foreach (exp_q[i]) if (i < got.size()) begin
        tests++;
        if (got[i] !== exp_q[i]) begin fails++; $display("FAIL pattern_word%0d e%0d: got %h u%0b l%0b, expected %h u%0b l%0b", i, e, got[i].d, got[i].u, got[i].l, exp_q[i].d, exp_q[i].u, exp_q[i].l); end
      end
      tests++; if (frame_cnt !== 16'd1) begin fails++; $display("FAIL pattern_frame_cnt e%0d: got %0d, expected 1", e, frame_cnt); end
    end
  endtask

  task automatic test_partial();
    endian = 1'b0; drop = '0; ena = 1'b1; axis.tready = 1'b1;
    do_reset();
    send_frame(2, 11, 1'b1, 1'b1);
    close_frame();
    tests++; if (got.size() < 2 || got[1] !== {64'h00000000000A0908, 1'b0, 1'b1}) begin fails++; $display("FAIL partial_second_word: got %h, expected 00000000000a0908 with tlast", (got.size() > 1) ? got[1].d : '0); end
    tests++; if (got.size() != exp_q.size()) begin fails++; $display("FAIL partial_count: got %0d words, expected %0d", got.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got.size()) begin
      tests++;
      if (got[i] !== exp_q[i]) begin fails++; $display("FAIL partial_word%0d: got %h u%0b l%0b, expected %h u%0b l%0b", i, got[i].d, got[i].u, got[i].l, exp_q[i].d, exp_q[i].u, exp_q[i].l); end
    end
  endtask

  task automatic test_decimation();
    endian = 1'b0; drop = 8'd2; ena = 1'b1; axis.tready = 1'b1;
    do_reset();
    for (int f = 0; f < 6; f++) send_frame(1, 8 + f, (f % 3) == 0, 1'b0);
    close_frame();
    tests++; if (frame_cnt !== 16'd2) begin fails++; $display("FAIL decim_frame_cnt: got %0d, expected 2", frame_cnt); end
    tests++; if (got.size() != exp_q.size()) begin fails++; $display("FAIL decim_count: got %0d words, expected %0d", got.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got.size()) begin
      tests++;
      if (got[i] !== exp_q[i]) begin fails++; $display("FAIL decim_word%0d: got %h u%0b l%0b, expected %h u%0b l%0b", i, got[i].d, got[i].u, got[i].l, exp_q[i].d, exp_q[i].u, exp_q[i].l); end
    end
  endtask

  task automatic test_random();
    int ncap;
    for (int it = 0; it < 4; it++) begin
      drop = 8'($urandom_range(0, 2)); endian = 1'($urandom_range(0, 1)); ena = 1'b1; axis.tready = 1'b1;
      do_reset();
      ncap = 0;
      for (int f = 0; f < 4; f++) begin
        bit cap = (f % (int'(drop) + 1)) == 0;
        if (cap) ncap++;
        send_frame($urandom_range(1, 3), $urandom_range(1, 40), cap, 1'b0);
      end
      close_frame();
      tests++; if (frame_cnt !== 16'(ncap)) begin fails++; $display("FAIL random_frame_cnt it%0d: got %0d, expected %0d", it, frame_cnt, ncap); end
      tests++; if (got.size() != exp_q.size()) begin fails++; $display("FAIL random_count it%0d: got %0d words, expected %0d", it, got.size(), exp_q.size()); end
      foreach (exp_q[i]) if (i < got.size()) begin
        tests++;
        if (got[i] !== exp_q[i]) begin fails++; $display("FAIL random_word%0d it%0d: got %h u%0b l%0b, expected %h u%0b l%0b", i, it, got[i].d, got[i].u, got[i].l, exp_q[i].d, exp_q[i].u, exp_q[i].l); end
      end
    end
  endtask

  task automatic test_latency();
    endian = 1'b0; drop = '0; ena = 1'b1; axis.tready = 1'b1;
    do_reset();
    vsync = 1'b1; repeat (4) @(negedge clk);
    vsync = 1'b0; repeat (3) @(negedge clk);
    for (int b = 0; b < K; b++) begin href = 1'b1; data = DW'(b); @(negedge clk); end
    href = 1'b0; data = '0;
    @(negedge clk);
    tests++; if (axis.tvalid !== 1'b0) begin fails++; $display("FAIL latency_one_cycle: got tvalid %b, expected 0", axis.tvalid); end
    @(negedge clk);
    tests++; if (axis.tvalid !== 1'b1) begin fails++; $display("FAIL latency_two_cycles: got tvalid %b, expected 1", axis.tvalid); end
    tests++; if ({axis.tdata, axis.tuser, axis.tlast} !== {64'h0706050403020100, 1'b1, 1'b1}) begin fails++; $display("FAIL latency_word: got %h u%0b l%0b, expected 0706050403020100 u1 l1", axis.tdata, axis.tuser, axis.tlast); end
    close_frame();
  endtask

  task automatic test_overflow();
    endian = 1'b0; drop = '0; ena = 1'b1; axis.tready = 1'b0;
    do_reset();
    send_frame(1, 24, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    tests++; if (ovf_cnt !== 16'd2) begin fails++; $display("FAIL ovf_count: got %0d, expected 2", ovf_cnt); end
    tests++; if (axis.tvalid !== 1'b1) begin fails++; $display("FAIL ovf_held_valid: got %b, expected 1", axis.tvalid); end
    tests++; if ({axis.tdata, axis.tuser, axis.tlast} !== {64'h0706050403020100, 1'b1, 1'b0}) begin fails++; $display("FAIL ovf_held_word: got %h u%0b l%0b, expected 0706050403020100 u1 l0", axis.tdata, axis.tuser, axis.tlast); end
    axis.tready = 1'b1;
    repeat (2) @(negedge clk);
    tests++; if (got.size() != 1 || got[0] !== {64'h0706050403020100, 1'b1, 1'b0}) begin fails++; $display("FAIL ovf_drain: got %0d words, expected 1 held word", got.size()); end
    tests++; if (axis.tvalid !== 1'b0) begin fails++; $display("FAIL ovf_after_drain: got tvalid %b, expected 0", axis.tvalid); end
    close_frame();
  endtask

  task automatic test_tuser_move();
    endian = 1'b0; drop = '0; ena = 1'b1; axis.tready = 1'b0;
    do_reset();
    send_frame(1, 8, 1'b0, 1'b1);
    vsync = 1'b1; repeat (4) @(negedge clk);
    vsync = 1'b0; repeat (3) @(negedge clk);
    for (int b = 0; b < 16; b++) begin
      href = 1'b1; data = DW'(8'h10 + b);
      @(negedge clk);
      if (b == 9) axis.tready = 1'b1;
    end
    href = 1'b0; data = '0;
    repeat (5) @(negedge clk);
    exp_q.push_back({64'h0706050403020100, 1'b1, 1'b1});
    exp_q.push_back({64'h1F1E1D1C1B1A1918, 1'b1, 1'b1});
    tests++; if (ovf_cnt !== 16'd1) begin fails++; $display("FAIL tuser_move_ovf: got %0d, expected 1", ovf_cnt); end
    tests++; if (got.size() != exp_q.size()) begin fails++; $display("FAIL tuser_move_count: got %0d words, expected %0d", got.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got.size()) begin
      tests++;
      if (got[i] !== exp_q[i]) begin fails++; $display("FAIL tuser_move_word%0d: got %h u%0b l%0b, expected %h u%0b l%0b", i, got[i].d, got[i].u, got[i].l, exp_q[i].d, exp_q[i].u, exp_q[i].l); end
    end
    close_frame();
  endtask

  task automatic test_reset_midline();
    endian = 1'b1; drop = '0; ena = 1'b1; axis.tready = 1'b0;
    do_reset();
    vsync = 1'b1; repeat (4) @(negedge clk);
    vsync = 1'b0; repeat (3) @(negedge clk);
    for (int b = 0; b < 12; b++) begin href = 1'b1; data = DW'(b); @(negedge clk); end
    tests++; if (axis.tvalid !== 1'b1) begin fails++; $display("FAIL midreset_pre_valid: got %b, expected 1", axis.tvalid); end
    #2 rst = 1'b1;
    #1;
    tests++; if (axis.tvalid !== 1'b0) begin fails++; $display("FAIL midreset_async_valid: got %b, expected 0", axis.tvalid); end
    @(negedge clk);
    rst = 1'b0;
    for (int b = 12; b < 18; b++) begin data = DW'(b); @(negedge clk); end
    href = 1'b0; data = '0; axis.tready = 1'b1;
    repeat (4) @(negedge clk);
    got.delete(); exp_q.delete(); sof = 1'b0;
    send_frame(1, 16, 1'b1, 1'b0);
    close_frame();
    tests++; if (got.size() != exp_q.size()) begin fails++; $display("FAIL midreset_count: got %0d words, expected %0d", got.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got.size()) begin
      tests++;
      if (got[i] !== exp_q[i]) begin fails++; $display("FAIL midreset_word%0d: got %h u%0b l%0b, expected %h u%0b l%0b", i, got[i].d, got[i].u, got[i].l, exp_q[i].d, exp_q[i].u, exp_q[i].l); end
    end
  endtask

`ifdef DVP_CROP_EN
  task automatic test_crop();
    endian = 1'b0; drop = '0; ena = 1'b1; axis.tready = 1'b1;
    x0 = CW'(8); x1 = CW'(15); y0 = CW'(1); y1 = CW'(1);
    do_reset();
    send_frame(4, 16, 1'b0, 1'b1);
    close_frame();
    tests++; if (got.size() != 1 || got[0] !== {64'h0F0E0D0C0B0A0908, 1'b1, 1'b1}) begin fails++; $display("FAIL crop_word: got %0d words, first %h, expected 1 word 0f0e0d0c0b0a0908 u1 l1", got.size(), (got.size() > 0) ? got[0].d : '0); end
    tests++; if (frame_cnt !== 16'd1) begin fails++; $display("FAIL crop_frame_cnt: got %0d, expected 1", frame_cnt); end
  endtask
`endif

  initial begin
`ifdef DVP_CROP_EN
    x0 = '0; x1 = '1; y0 = '0; y1 = '1;
`endif
    test_reset();
    test_pattern();
    test_partial();
    test_decimation();
    test_latency();
    test_overflow();
    test_tuser_move();
    test_reset_midline();
    test_random();
`ifdef DVP_CROP_EN
    test_crop();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
